// File: rtl/trig_sequencer_if.sv
// ---------------------------------------------------------------------------
// trig_sequencer_if
// Groups the command/status signals between the trigger source (decoder side)
// and the trig_sequencer pulse-train generator.
//   I_trig       : one-cycle start strobe
//   I_trig_num   : number of pulses N
//   I_trig_step  : period between pulse rising edges S
//   I_wait       : delay before the first pulse W
//   I_abort      : synchronous abort of the running train
//   O_trig_pulse : pulse-train output
//   O_pulse_idx  : 0-based index of the most recent pulse
//   O_busy       : train in progress
//   O_done       : one-cycle completion strobe
//   O_overrun    : one-cycle strobe for a trigger that arrived while busy
// master = command source / status sink, slave = sequencer.
// ---------------------------------------------------------------------------
interface trig_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             I_trig;
    logic [CNT_W-1:0] I_trig_num;
    logic [CNT_W-1:0] I_trig_step;
    logic [CNT_W-1:0] I_wait;
    logic             I_abort;
    logic             O_trig_pulse;
    logic [CNT_W-1:0] O_pulse_idx;
    logic             O_busy;
    logic             O_done;
    logic             O_overrun;

    modport master (
        output I_trig, I_trig_num, I_trig_step, I_wait, I_abort,
        input  O_trig_pulse, O_pulse_idx, O_busy, O_done, O_overrun
    );

    modport slave (
        input  I_trig, I_trig_num, I_trig_step, I_wait, I_abort,
        output O_trig_pulse, O_pulse_idx, O_busy, O_done, O_overrun
    );
endinterface

// File: rtl/trig_sequencer.sv
// ---------------------------------------------------------------------------
// trig_sequencer
// Turns one decoded trigger command (count N, step S, wait W) into a timed
// train of PULSE_WIDTH-cycle pulses, reporting busy/done/overrun status.
// Ports:
//   I_clk   : clock (decoder read-side clock)
//   I_rst_n : asynchronous active-low reset
//   bus     : trig_sequencer_if slave modport (command inputs, status outputs)
// ---------------------------------------------------------------------------
module trig_sequencer #(
    parameter int PULSE_WIDTH = 4,
    parameter int CNT_W       = 32
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    trig_sequencer_if.slave       bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PULSE,
        ST_GAP,
        ST_FINISH
    } state_t;

    localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_PW_M1  = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] LP_MIN_P  = CNT_W'(PULSE_WIDTH + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_gapM1;
    logic [CNT_W-1:0] r_idx;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;

    state_t           w_nextState;
    logic [CNT_W-1:0] w_nextCnt;
    logic [CNT_W-1:0] w_nextRem;
    logic [CNT_W-1:0] w_nextGapM1;
    logic [CNT_W-1:0] w_nextIdx;
    logic             w_overrun;
    logic [CNT_W-1:0] w_period;
    logic             w_accept;

    // Effective period is clamped so every pulse is followed by at least one
    // low cycle; only the gap length minus one needs to be kept per train.
    assign w_period = (bus.I_trig_step > LP_MIN_P) ? bus.I_trig_step : LP_MIN_P;

    // A new command is taken only from IDLE or FINISH, and abort always wins.
    assign w_accept = bus.I_trig && !bus.I_abort &&
                      ((r_state == ST_IDLE) || (r_state == ST_FINISH));

    // State register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and counter logic. r_cnt counts down the cycles left in the
    // current WAIT/PULSE/GAP phase; r_rem counts pulses still to come after
    // the current one, so no counter ever needs to hold N or W plus one.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextRem   = r_rem;
        w_nextGapM1 = r_gapM1;
        w_nextIdx   = r_idx;
        w_overrun   = 1'b0;
        case (r_state)
            ST_IDLE, ST_FINISH: begin
                w_nextState = ST_IDLE;
                if (w_accept) begin
                    w_nextGapM1 = w_period - LP_MIN_P;
                    if (bus.I_trig_num == '0) begin
                        w_nextState = ST_FINISH;
                    end else begin
                        w_nextIdx = '0;
                        w_nextRem = bus.I_trig_num - LP_ONE;
                        if (bus.I_wait == '0) begin
                            w_nextState = ST_PULSE;
                            w_nextCnt   = LP_PW_M1;
                        end else begin
                            w_nextState = ST_WAIT;
                            w_nextCnt   = bus.I_wait - LP_ONE;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (bus.I_abort) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_overrun = bus.I_trig;
                    if (r_cnt == '0) begin
                        w_nextState = ST_PULSE;
                        w_nextCnt   = LP_PW_M1;
                    end else begin
                        w_nextCnt = r_cnt - LP_ONE;
                    end
                end
            end
            ST_PULSE: begin
                if (bus.I_abort) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_overrun = bus.I_trig;
                    if (r_cnt == '0) begin
                        if (r_rem == '0) begin
                            w_nextState = ST_FINISH;
                        end else begin
                            w_nextState = ST_GAP;
                            w_nextCnt   = r_gapM1;
                        end
                    end else begin
                        w_nextCnt = r_cnt - LP_ONE;
                    end
                end
            end
            ST_GAP: begin
                if (bus.I_abort) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_overrun = bus.I_trig;
                    if (r_cnt == '0) begin
                        w_nextState = ST_PULSE;
                        w_nextCnt   = LP_PW_M1;
                        w_nextIdx   = r_idx + LP_ONE;
                        w_nextRem   = r_rem - LP_ONE;
                    end else begin
                        w_nextCnt = r_cnt - LP_ONE;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs, decoded from the next state
    // so each output lines up with the state it describes.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_gapM1   <= '0;
            r_idx     <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt     <= w_nextCnt;
            r_rem     <= w_nextRem;
            r_gapM1   <= w_nextGapM1;
            r_idx     <= w_nextIdx;
            r_pulse   <= (w_nextState == ST_PULSE);
            r_busy    <= (w_nextState == ST_WAIT) || (w_nextState == ST_PULSE) ||
                         (w_nextState == ST_GAP);
            r_done    <= (w_nextState == ST_FINISH);
            r_overrun <= w_overrun;
        end
    end

    assign bus.O_trig_pulse = r_pulse;
    assign bus.O_pulse_idx  = r_idx;
    assign bus.O_busy       = r_busy;
    assign bus.O_done       = r_done;
    assign bus.O_overrun    = r_overrun;

endmodule

// File: tb/tb_trig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trig_sequencer
// Directed self-checking bench for trig_sequencer (PULSE_WIDTH=4, CNT_W=32).
// Inputs are driven and outputs sampled on the falling clock edge; "cycle c"
// means the c-th clock period after the one in which I_trig was driven.
// ---------------------------------------------------------------------------
module tb_trig_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    trig_sequencer_if #(.CNT_W(32)) bus();

    trig_sequencer #(
        .PULSE_WIDTH (4),
        .CNT_W       (32)
    ) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    // Drives a one-cycle trigger from the current falling edge; returns at
    // the falling edge of cycle 1 with I_trig released.
    task automatic startTrig(input logic [31:0] n, input logic [31:0] s, input logic [31:0] w);
        bus.I_trig      = 1'b1;
        bus.I_trig_num  = n;
        bus.I_trig_step = s;
        bus.I_wait      = w;
        @(negedge clk);
        bus.I_trig      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.I_trig = 1'b0; bus.I_abort = 1'b0;
        bus.I_trig_num = '0; bus.I_trig_step = '0; bus.I_wait = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.O_trig_pulse, bus.O_busy, bus.O_done, bus.O_overrun} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {bus.O_trig_pulse, bus.O_busy, bus.O_done, bus.O_overrun});
        else passes++;
        checks++;
        if (bus.O_pulse_idx !== 32'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", bus.O_pulse_idx);
        else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.O_trig_pulse, bus.O_busy, bus.O_done, bus.O_overrun} !== 4'b0000)
            $display("[TB] FAIL post_reset_idle: got %b expected 0000", {bus.O_trig_pulse, bus.O_busy, bus.O_done, bus.O_overrun});
        else passes++;
    endtask

    // N=3, S=10, W=0: rises at 1, 11, 21; done at 25; busy 1..24.
    task automatic test_basic();
        logic ePulse, eBusy, eDone;
        startTrig(32'd3, 32'd10, 32'd0);
        for (int c = 1; c <= 27; c++) begin
            ePulse = (c >= 1 && c <= 4) || (c >= 11 && c <= 14) || (c >= 21 && c <= 24);
            eBusy  = (c >= 1 && c <= 24);
            eDone  = (c == 25);
            checks++;
            if (bus.O_trig_pulse !== ePulse) $display("[TB] FAIL basic_pulse c=%0d: got %b expected %b", c, bus.O_trig_pulse, ePulse);
            else passes++;
            checks++;
            if (bus.O_busy !== eBusy) $display("[TB] FAIL basic_busy c=%0d: got %b expected %b", c, bus.O_busy, eBusy);
            else passes++;
            checks++;
            if (bus.O_done !== eDone) $display("[TB] FAIL basic_done c=%0d: got %b expected %b", c, bus.O_done, eDone);
            else passes++;
            if (c == 1 || c == 11 || c == 21) begin
                checks++;
                if (bus.O_pulse_idx !== 32'((c - 1) / 10)) $display("[TB] FAIL basic_idx c=%0d: got %0d expected %0d", c, bus.O_pulse_idx, (c - 1) / 10);
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    // N=2, S=2 (clamped to 5), W=5: rises at 6 and 11; done at 15.
    task automatic test_clamp();
        logic ePulse, eBusy, eDone;
        startTrig(32'd2, 32'd2, 32'd5);
        for (int c = 1; c <= 17; c++) begin
            ePulse = (c >= 6 && c <= 9) || (c >= 11 && c <= 14);
            eBusy  = (c >= 1 && c <= 14);
            eDone  = (c == 15);
            checks++;
            if (bus.O_trig_pulse !== ePulse) $display("[TB] FAIL clamp_pulse c=%0d: got %b expected %b", c, bus.O_trig_pulse, ePulse);
            else passes++;
            checks++;
            if (bus.O_busy !== eBusy) $display("[TB] FAIL clamp_busy c=%0d: got %b expected %b", c, bus.O_busy, eBusy);
            else passes++;
            checks++;
            if (bus.O_done !== eDone) $display("[TB] FAIL clamp_done c=%0d: got %b expected %b", c, bus.O_done, eDone);
            else passes++;
            if (c == 11) begin
                checks++;
                if (bus.O_pulse_idx !== 32'd1) $display("[TB] FAIL clamp_idx: got %0d expected 1", bus.O_pulse_idx);
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    // N=0, W=100: done at cycle 1, never busy, index left at 1.
    task automatic test_zero_count();
        startTrig(32'd0, 32'd10, 32'd100);
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (bus.O_done !== (c == 1)) $display("[TB] FAIL zero_done c=%0d: got %b expected %b", c, bus.O_done, (c == 1));
            else passes++;
            checks++;
            if ({bus.O_busy, bus.O_trig_pulse} !== 2'b00) $display("[TB] FAIL zero_busy_pulse c=%0d: got %b expected 00", c, {bus.O_busy, bus.O_trig_pulse});
            else passes++;
            checks++;
            if (bus.O_pulse_idx !== 32'd1) $display("[TB] FAIL zero_idx c=%0d: got %0d expected 1", c, bus.O_pulse_idx);
            else passes++;
            @(negedge clk);
        end
    endtask

    // N=4, S=8, W=0 with a stray trigger at 9 (overrun at 10), done at 29,
    // then a new N=1 train triggered in the done cycle: pulse 30..33, done 34.
    task automatic test_back_to_back();
        logic ePulse, eBusy, eDone, eOver;
        startTrig(32'd4, 32'd8, 32'd0);
        for (int c = 1; c <= 36; c++) begin
            ePulse = (c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20) ||
                     (c >= 25 && c <= 28) || (c >= 30 && c <= 33);
            eBusy  = (c >= 1 && c <= 28) || (c >= 30 && c <= 33);
            eDone  = (c == 29) || (c == 34);
            eOver  = (c == 10);
            checks++;
            if (bus.O_trig_pulse !== ePulse) $display("[TB] FAIL b2b_pulse c=%0d: got %b expected %b", c, bus.O_trig_pulse, ePulse);
            else passes++;
            checks++;
            if (bus.O_busy !== eBusy) $display("[TB] FAIL b2b_busy c=%0d: got %b expected %b", c, bus.O_busy, eBusy);
            else passes++;
            checks++;
            if (bus.O_done !== eDone) $display("[TB] FAIL b2b_done c=%0d: got %b expected %b", c, bus.O_done, eDone);
            else passes++;
            checks++;
            if (bus.O_overrun !== eOver) $display("[TB] FAIL b2b_overrun c=%0d: got %b expected %b", c, bus.O_overrun, eOver);
            else passes++;
            if (c == 25 || c == 30) begin
                checks++;
                if (bus.O_pulse_idx !== ((c == 25) ? 32'd3 : 32'd0)) $display("[TB] FAIL b2b_idx c=%0d: got %0d expected %0d", c, bus.O_pulse_idx, (c == 25) ? 3 : 0);
                else passes++;
            end
            bus.I_trig = (c == 9) || (c == 29);
            if (c == 9) begin
                bus.I_trig_num = 32'd1; bus.I_trig_step = 32'd1; bus.I_wait = 32'd1;
            end
            if (c == 29) begin
                bus.I_trig_num = 32'd1; bus.I_trig_step = 32'd0; bus.I_wait = 32'd0;
            end
            @(negedge clk);
        end
        bus.I_trig = 1'b0;
    endtask

    // N=5, S=10, abort at 12 (second pulse high): quiet from 13, index 1.
    // Then abort and trigger together in IDLE: nothing starts.
    task automatic test_abort();
        logic ePulse, eBusy;
        startTrig(32'd5, 32'd10, 32'd0);
        for (int c = 1; c <= 20; c++) begin
            ePulse = (c >= 1 && c <= 4) || (c >= 11 && c <= 12);
            eBusy  = (c >= 1 && c <= 12);
            checks++;
            if (bus.O_trig_pulse !== ePulse) $display("[TB] FAIL abort_pulse c=%0d: got %b expected %b", c, bus.O_trig_pulse, ePulse);
            else passes++;
            checks++;
            if (bus.O_busy !== eBusy) $display("[TB] FAIL abort_busy c=%0d: got %b expected %b", c, bus.O_busy, eBusy);
            else passes++;
            checks++;
            if (bus.O_done !== 1'b0) $display("[TB] FAIL abort_done c=%0d: got %b expected 0", c, bus.O_done);
            else passes++;
            if (c == 13 || c == 20) begin
                checks++;
                if (bus.O_pulse_idx !== 32'd1) $display("[TB] FAIL abort_idx c=%0d: got %0d expected 1", c, bus.O_pulse_idx);
                else passes++;
            end
            bus.I_abort = (c == 12);
            @(negedge clk);
        end
        bus.I_abort = 1'b1;
        startTrig(32'd1, 32'd0, 32'd0);
        bus.I_abort = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if ({bus.O_trig_pulse, bus.O_busy, bus.O_done, bus.O_overrun} !== 4'b0000)
                $display("[TB] FAIL abort_trig_idle c=%0d: got %b expected 0000", c, {bus.O_trig_pulse, bus.O_busy, bus.O_done, bus.O_overrun});
            else passes++;
            @(negedge clk);
        end
    endtask

    // Reset in the second gap of an N=3, S=10 train, then a fresh N=1 train.
    task automatic test_reset_mid_train();
        startTrig(32'd3, 32'd10, 32'd0);
        repeat (15) @(negedge clk);
        checks++;
        if ({bus.O_busy, bus.O_trig_pulse, bus.O_pulse_idx} !== {2'b10, 32'd1})
            $display("[TB] FAIL pre_reset_gap: got busy=%b pulse=%b idx=%0d expected busy=1 pulse=0 idx=1", bus.O_busy, bus.O_trig_pulse, bus.O_pulse_idx);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.O_trig_pulse, bus.O_busy, bus.O_done, bus.O_overrun} !== 4'b0000)
            $display("[TB] FAIL async_reset_flags: got %b expected 0000", {bus.O_trig_pulse, bus.O_busy, bus.O_done, bus.O_overrun});
        else passes++;
        checks++;
        if (bus.O_pulse_idx !== 32'd0) $display("[TB] FAIL async_reset_idx: got %0d expected 0", bus.O_pulse_idx);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.O_trig_pulse, bus.O_busy, bus.O_done} !== 3'b000)
                $display("[TB] FAIL after_reset_quiet c=%0d: got %b expected 000", c, {bus.O_trig_pulse, bus.O_busy, bus.O_done});
            else passes++;
        end
        startTrig(32'd1, 32'd0, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (bus.O_trig_pulse !== (c <= 4)) $display("[TB] FAIL fresh_pulse c=%0d: got %b expected %b", c, bus.O_trig_pulse, (c <= 4));
            else passes++;
            checks++;
            if (bus.O_done !== (c == 5)) $display("[TB] FAIL fresh_done c=%0d: got %b expected %b", c, bus.O_done, (c == 5));
            else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_zero_count();
        test_back_to_back();
        test_abort();
        test_reset_mid_train();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
